// File: rtl/wts_channel_register_pkg.sv
// Shared definitions for the wave-table sound channel register bank:
// register offsets, staging pair identifiers and control-byte bit positions.
package wts_reg_pkg;

  localparam logic [3:0] WTS_OFS_FREQ_L = 4'h0;
  localparam logic [3:0] WTS_OFS_FREQ_H = 4'h1;
  localparam logic [3:0] WTS_OFS_CTRL   = 4'h2;
  localparam logic [3:0] WTS_OFS_WAVE   = 4'h3;
  localparam logic [3:0] WTS_OFS_AR_L   = 4'h4;
  localparam logic [3:0] WTS_OFS_AR_H   = 4'h5;
  localparam logic [3:0] WTS_OFS_DR_L   = 4'h6;
  localparam logic [3:0] WTS_OFS_DR_H   = 4'h7;
  localparam logic [3:0] WTS_OFS_SR_L   = 4'h8;
  localparam logic [3:0] WTS_OFS_SR_H   = 4'h9;
  localparam logic [3:0] WTS_OFS_RR_L   = 4'hA;
  localparam logic [3:0] WTS_OFS_RR_H   = 4'hB;
  localparam logic [3:0] WTS_OFS_SL     = 4'hC;

  typedef enum logic [2:0] {
    PAIR_FREQ = 3'd0,
    PAIR_AR   = 3'd1,
    PAIR_DR   = 3'd2,
    PAIR_SR   = 3'd3,
    PAIR_RR   = 3'd4
  } wts_pair_e;

  // Bit layout of the control byte at offset 0x2 (bit 5 is unused)
  localparam int WTS_CTRL_VOL_LSB   = 0;
  localparam int WTS_CTRL_VOL_MSB   = 3;
  localparam int WTS_CTRL_NOISE_BIT = 4;
  localparam int WTS_CTRL_EN_LSB    = 6;
  localparam int WTS_CTRL_EN_MSB    = 7;

  // High byte always lands; the low half takes the staged byte only when the
  // staging slot was armed for this very pair.
  function automatic logic [15:0] wts_commit(input logic [15:0] cur,
                                             input logic [7:0]  hi,
                                             input logic [7:0]  stg,
                                             input logic        hit);
    return {hi, (hit ? stg : cur[7:0])};
  endfunction

endpackage

// File: rtl/wts_channel_register_if.sv
// Byte-wide CPU bus between the bus interface (master) and one channel
// register bank (slave).
interface wts_channel_register_if;

  logic       bus_ioreq;
  logic       bus_write;
  logic [7:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_ioreq, bus_write, bus_address, bus_wdata,
    input  bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_ioreq, bus_write, bus_address, bus_wdata,
    output bus_rdata, bus_rdata_en
  );

endinterface

// File: rtl/wts_channel_register.sv
// CPU-side register bank for one wave-table sound channel. Wide fields are
// double-buffered through a shared staging byte so the mixer never sees a torn value.
module wts_channel_register
  import wts_reg_pkg::*;
#(
  parameter int CHANNEL_ID = 0
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    sw_clear,
  wts_channel_register_if.slave   bus,
  output logic [3:0]              reg_volume,
  output logic [1:0]              reg_enable,
  output logic                    reg_noise_enable,
  output logic [15:0]             reg_ar,
  output logic [15:0]             reg_dr,
  output logic [15:0]             reg_sr,
  output logic [15:0]             reg_rr,
  output logic [7:0]              reg_sl,
  output logic [1:0]              reg_wave_length,
  output logic [11:0]             reg_frequency_count
);

  logic       selected;
  logic       wr_sel;
  logic       rd_sel;
  logic [3:0] offset;
  logic [7:0] wdata;
  logic [7:0] read_value;

  logic       [7:0] staging;
  logic             pending;
  wts_pair_e        stage_pair;

  assign selected = bus.bus_ioreq && (bus.bus_address[7:4] == 4'(CHANNEL_ID));
  assign wr_sel   = selected && bus.bus_write;
  assign rd_sel   = selected && !bus.bus_write;
  assign offset   = bus.bus_address[3:0];
  assign wdata    = bus.bus_wdata;

  // Write decode and commit; sw_clear wins over a same-cycle write
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      reg_volume          <= '0;
      reg_enable          <= '0;
      reg_noise_enable    <= 1'b0;
      reg_ar              <= '0;
      reg_dr              <= '0;
      reg_sr              <= '0;
      reg_rr              <= '0;
      reg_sl              <= '0;
      reg_wave_length     <= '0;
      reg_frequency_count <= '0;
      staging             <= '0;
      pending             <= 1'b0;
      stage_pair          <= PAIR_FREQ;
    end else if (sw_clear) begin
      reg_volume          <= '0;
      reg_enable          <= '0;
      reg_noise_enable    <= 1'b0;
      reg_ar              <= '0;
      reg_dr              <= '0;
      reg_sr              <= '0;
      reg_rr              <= '0;
      reg_sl              <= '0;
      reg_wave_length     <= '0;
      reg_frequency_count <= '0;
      staging             <= '0;
      pending             <= 1'b0;
      stage_pair          <= PAIR_FREQ;
    end else if (wr_sel) begin
      case (offset)
        WTS_OFS_FREQ_L: begin
          staging    <= wdata;
          pending    <= 1'b1;
          stage_pair <= PAIR_FREQ;
        end
        WTS_OFS_FREQ_H: begin
          reg_frequency_count <= {wdata[3:0],
                                  ((pending && stage_pair == PAIR_FREQ) ? staging
                                                                        : reg_frequency_count[7:0])};
          pending <= 1'b0;
        end
        WTS_OFS_CTRL: begin
          reg_volume       <= wdata[WTS_CTRL_VOL_MSB:WTS_CTRL_VOL_LSB];
          reg_noise_enable <= wdata[WTS_CTRL_NOISE_BIT];
          reg_enable       <= wdata[WTS_CTRL_EN_MSB:WTS_CTRL_EN_LSB];
        end
        WTS_OFS_WAVE: reg_wave_length <= wdata[1:0];
        WTS_OFS_AR_L: begin
          staging    <= wdata;
          pending    <= 1'b1;
          stage_pair <= PAIR_AR;
        end
        WTS_OFS_AR_H: begin
          reg_ar  <= wts_commit(reg_ar, wdata, staging, pending && stage_pair == PAIR_AR);
          pending <= 1'b0;
        end
        WTS_OFS_DR_L: begin
          staging    <= wdata;
          pending    <= 1'b1;
          stage_pair <= PAIR_DR;
        end
        WTS_OFS_DR_H: begin
          reg_dr  <= wts_commit(reg_dr, wdata, staging, pending && stage_pair == PAIR_DR);
          pending <= 1'b0;
        end
        WTS_OFS_SR_L: begin
          staging    <= wdata;
          pending    <= 1'b1;
          stage_pair <= PAIR_SR;
        end
        WTS_OFS_SR_H: begin
          reg_sr  <= wts_commit(reg_sr, wdata, staging, pending && stage_pair == PAIR_SR);
          pending <= 1'b0;
        end
        WTS_OFS_RR_L: begin
          staging    <= wdata;
          pending    <= 1'b1;
          stage_pair <= PAIR_RR;
        end
        WTS_OFS_RR_H: begin
          reg_rr  <= wts_commit(reg_rr, wdata, staging, pending && stage_pair == PAIR_RR);
          pending <= 1'b0;
        end
        WTS_OFS_SL: reg_sl <= wdata;
        default: ;
      endcase
    end
  end

  // Readback shows committed values only, never the staging byte
  always_comb begin
    read_value = 8'h00;
    case (offset)
      WTS_OFS_FREQ_L: read_value = reg_frequency_count[7:0];
      WTS_OFS_FREQ_H: read_value = {4'h0, reg_frequency_count[11:8]};
      WTS_OFS_CTRL:   read_value = {reg_enable, 1'b0, reg_noise_enable, reg_volume};
      WTS_OFS_WAVE:   read_value = {6'h00, reg_wave_length};
      WTS_OFS_AR_L:   read_value = reg_ar[7:0];
      WTS_OFS_AR_H:   read_value = reg_ar[15:8];
      WTS_OFS_DR_L:   read_value = reg_dr[7:0];
      WTS_OFS_DR_H:   read_value = reg_dr[15:8];
      WTS_OFS_SR_L:   read_value = reg_sr[7:0];
      WTS_OFS_SR_H:   read_value = reg_sr[15:8];
      WTS_OFS_RR_L:   read_value = reg_rr[7:0];
      WTS_OFS_RR_H:   read_value = reg_rr[15:8];
      WTS_OFS_SL:     read_value = reg_sl;
      default:        read_value = 8'h00;
    endcase
  end

  // Read data is sampled from pre-edge state, so a read alongside sw_clear
  // still returns the old value
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.bus_rdata    <= 8'h00;
      bus.bus_rdata_en <= 1'b0;
    end else begin
      bus.bus_rdata_en <= rd_sel;
      if (rd_sel) begin
        bus.bus_rdata <= read_value;
      end
    end
  end

endmodule
